// File: rtl/crc_frame_writer.sv
// crc_frame_writer: writes a byte stream into frame memory from address 0 and
// appends the CRC-16/CCITT-FALSE of the payload (high byte, then low byte).
// The last completed frame's CRC and length are held on the outputs.
// MAX_LEN + 2 must not exceed 2**ADDR_W so the two CRC bytes fit.
module crc_frame_writer #(
   parameter int ADDR_W  = 10,
   parameter int MAX_LEN = 1022
) (
   input  logic              i_clk50m,
   input  logic              i_rst_n,
   input  logic              i_wr_start,
   input  logic [7:0]        i_in_data,
   input  logic              i_in_valid,
   input  logic              i_in_last,
   output logic              o_in_ready,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_wdata,
   output logic              o_mem_we,
   output logic [15:0]       o_crc_out,
   output logic [ADDR_W-1:0] o_frame_len,
   output logic              o_wr_done,
   output logic              o_wr_err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_CRC_HI = 3'd2,
      S_CRC_LO = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // Pointer value of the final byte a frame may carry before it is cut short.
   localparam logic [ADDR_W-1:0] LP_LAST_PTR = ADDR_W'(MAX_LEN - 1);
   localparam logic [ADDR_W-1:0] LP_ONE      = ADDR_W'(1);

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_ptr,       w_ptr_next;
   logic [15:0]       r_crc,       w_crc_next;
   logic              r_mem_we,    w_mem_we_next;
   logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_next;
   logic [7:0]        r_mem_wdata, w_mem_wdata_next;
   logic [15:0]       r_crc_out,   w_crc_out_next;
   logic [ADDR_W-1:0] r_frame_len, w_frame_len_next;
   logic              r_wr_done,   w_wr_done_next;
   logic              r_wr_err,    w_wr_err_next;
   logic              w_accept;
   logic [15:0]       w_crc_byte;

   // One full byte of CRC-16 (poly 0x1021, MSB first), eight bit steps unrolled.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                              input logic [7:0]  data_in);
      logic [15:0] c;
      c = crc_in ^ {data_in, 8'h00};
      for (int k = 0; k < 8; k++) begin
         if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else       c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   assign o_in_ready = (r_state == S_DATA);
   assign w_accept   = o_in_ready & i_in_valid;
   assign w_crc_byte = crc16_byte(r_crc, i_in_data);

   // State register.
   always_ff @(posedge i_clk50m or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state and next-value decode for the datapath registers.
   always_comb begin
      w_state_next     = r_state;
      w_ptr_next       = r_ptr;
      w_crc_next       = r_crc;
      w_mem_we_next    = 1'b0;
      w_mem_addr_next  = r_mem_addr;
      w_mem_wdata_next = r_mem_wdata;
      w_crc_out_next   = r_crc_out;
      w_frame_len_next = r_frame_len;
      w_wr_done_next   = 1'b0;
      w_wr_err_next    = r_wr_err;
      case (r_state)
         S_IDLE: begin
            if (i_wr_start) begin
               w_ptr_next    = '0;
               w_crc_next    = 16'hFFFF;
               w_wr_err_next = 1'b0;
               w_state_next  = S_DATA;
            end
         end
         S_DATA: begin
            if (w_accept) begin
               w_mem_we_next    = 1'b1;
               w_mem_addr_next  = r_ptr;
               w_mem_wdata_next = i_in_data;
               w_crc_next       = w_crc_byte;
               w_ptr_next       = r_ptr + LP_ONE;
               if (i_in_last) begin
                  w_state_next = S_CRC_HI;
               end else if (r_ptr == LP_LAST_PTR) begin
                  // Buffer full: close the frame here and flag the overflow.
                  w_wr_err_next = 1'b1;
                  w_state_next  = S_CRC_HI;
               end
            end
         end
         S_CRC_HI: begin
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = r_ptr;
            w_mem_wdata_next = r_crc[15:8];
            w_ptr_next       = r_ptr + LP_ONE;
            w_state_next     = S_CRC_LO;
         end
         S_CRC_LO: begin
            w_mem_we_next    = 1'b1;
            w_mem_addr_next  = r_ptr;
            w_mem_wdata_next = r_crc[7:0];
            w_state_next     = S_DONE;
         end
         S_DONE: begin
            w_wr_done_next   = 1'b1;
            w_crc_out_next   = r_crc;
            // ptr sits on the CRC low byte address, one past the payload count.
            w_frame_len_next = r_ptr - LP_ONE;
            w_state_next     = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge i_clk50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_crc       <= 16'hFFFF;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_crc_out   <= '0;
         r_frame_len <= '0;
         r_wr_done   <= 1'b0;
         r_wr_err    <= 1'b0;
      end else begin
         r_ptr       <= w_ptr_next;
         r_crc       <= w_crc_next;
         r_mem_we    <= w_mem_we_next;
         r_mem_addr  <= w_mem_addr_next;
         r_mem_wdata <= w_mem_wdata_next;
         r_crc_out   <= w_crc_out_next;
         r_frame_len <= w_frame_len_next;
         r_wr_done   <= w_wr_done_next;
         r_wr_err    <= w_wr_err_next;
      end
   end

   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_crc_out   = r_crc_out;
   assign o_frame_len = r_frame_len;
   assign o_wr_done   = r_wr_done;
   assign o_wr_err    = r_wr_err;

endmodule

// File: tb/tb_crc_frame_writer.sv
// Directed bench for crc_frame_writer: a default instance (A) and a MAX_LEN=4
// instance (B) share data inputs; wr_start is steered to one of them by sel.
module tb_crc_frame_writer;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic       rst_n, wr_start, in_valid, in_last, sel;
   logic [7:0] in_data;
   logic       wr_start_a, wr_start_b;
   assign wr_start_a = wr_start & ~sel;
   assign wr_start_b = wr_start & sel;

   logic       a_ready, a_we, a_done, a_err;
   logic [9:0] a_addr, a_len;
   logic [7:0] a_wdata;
   logic [15:0] a_crc;
   logic       b_ready, b_we, b_done, b_err;
   logic [9:0] b_addr, b_len;
   logic [7:0] b_wdata;
   logic [15:0] b_crc;

   crc_frame_writer #(.ADDR_W(10), .MAX_LEN(1022)) u_dut_a (
      .i_clk50m(clk), .i_rst_n(rst_n), .i_wr_start(wr_start_a),
      .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last),
      .o_in_ready(a_ready), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
      .o_mem_we(a_we), .o_crc_out(a_crc), .o_frame_len(a_len),
      .o_wr_done(a_done), .o_wr_err(a_err));

   crc_frame_writer #(.ADDR_W(10), .MAX_LEN(4)) u_dut_b (
      .i_clk50m(clk), .i_rst_n(rst_n), .i_wr_start(wr_start_b),
      .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last),
      .o_in_ready(b_ready), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
      .o_mem_we(b_we), .o_crc_out(b_crc), .o_frame_len(b_len),
      .o_wr_done(b_done), .o_wr_err(b_err));

   logic        w_ready, w_we, w_done, w_err;
   logic [9:0]  w_len;
   logic [15:0] w_crc;
   assign w_ready = sel ? b_ready : a_ready;
   assign w_we    = sel ? b_we    : a_we;
   assign w_done  = sel ? b_done  : a_done;
   assign w_err   = sel ? b_err   : a_err;
   assign w_len   = sel ? b_len   : a_len;
   assign w_crc   = sel ? b_crc   : a_crc;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int done_cnt = 0, we_cnt = 0, nacc_cnt = 0;
   logic prev_acc = 1'b0;
   logic [7:0] mem_a [0:1023];
   logic [7:0] mem_b [0:1023];
   logic [7:0] tx [0:15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Memory models and per-frame write/done accounting, sampled mid-cycle.
   always @(negedge clk) begin
      if (a_we) mem_a[a_addr] = a_wdata;
      if (b_we) mem_b[b_addr] = b_wdata;
      if (w_done) done_cnt++;
      if (w_we) begin
         we_cnt++;
         if (!prev_acc) nacc_cnt++;
      end
      prev_acc = w_ready & in_valid;
   end

   task automatic clear_counts();
      done_cnt = 0; we_cnt = 0; nacc_cnt = 0;
   endtask

   task automatic load_digits();
      for (int i = 0; i < 9; i++) tx[i] = 8'h31 + 8'(i);
   endtask

   task automatic send_frame(input int n, input int gap_max, input int mid_start);
      int t;
      wr_start = 1'b1;
      @(posedge clk); #1 wr_start = 1'b0;
      clear_counts();
      for (int i = 0; i < n; i++) begin
         if (i == mid_start) begin
            wr_start = 1'b1;
            @(posedge clk); #1 wr_start = 1'b0;
         end
         if (gap_max > 0 && i > 0) begin
            repeat ($urandom_range(gap_max, 1)) @(posedge clk);
            #1;
         end
         in_data  = tx[i];
         in_valid = 1'b1;
         in_last  = (i == n - 1);
         t = 0;
         @(negedge clk);
         while (!w_ready && t < 20) begin
            t++;
            @(negedge clk);
         end
         if (t >= 20) check("ready_timeout", {31'd0, w_ready}, 32'd1);
         @(posedge clk); #1;
         acc_cyc  = cyc;
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag, input int n, input logic [15:0] exp_crc,
                            input logic exp_err);
      int t;
      logic [7:0] m;
      t = 0;
      @(negedge clk);
      while (!w_done && t < 30) begin
         t++;
         @(negedge clk);
      end
      check({tag, "_done"}, {31'd0, w_done}, 32'd1);
      check({tag, "_lat"}, cyc - acc_cyc, 32'd3);
      check({tag, "_crc"}, {16'd0, w_crc}, {16'd0, exp_crc});
      check({tag, "_len"}, {22'd0, w_len}, n);
      check({tag, "_err"}, {31'd0, w_err}, {31'd0, exp_err});
      $display("frame %s: crc_out=0x%04h frame_len=%0d wr_err=%0d", tag, w_crc, w_len, w_err);
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, w_done}, 32'd0);
      check({tag, "_ndone"}, done_cnt, 32'd1);
      check({tag, "_nwe"}, we_cnt, n + 2);
      check({tag, "_we_noacc"}, nacc_cnt, 32'd2);
      for (int i = 0; i < n + 2; i++) begin
         m = sel ? mem_b[i] : mem_a[i];
         if (i < n)       check($sformatf("%s_m%0d", tag, i), {24'd0, m}, {24'd0, tx[i]});
         else if (i == n) check($sformatf("%s_m%0d", tag, i), {24'd0, m}, {24'd0, exp_crc[15:8]});
         else             check($sformatf("%s_m%0d", tag, i), {24'd0, m}, {24'd0, exp_crc[7:0]});
      end
   endtask

   initial begin
      logic r;
      int acc;
      rst_n = 1'b0; wr_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = 8'h00; sel = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, a_ready}, 32'd0);
      check("rst_we", {31'd0, a_we}, 32'd0);
      check("rst_addr", {22'd0, a_addr}, 32'd0);
      check("rst_wdata", {24'd0, a_wdata}, 32'd0);
      check("rst_crc", {16'd0, a_crc}, 32'd0);
      check("rst_len", {22'd0, a_len}, 32'd0);
      check("rst_done", {31'd0, a_done}, 32'd0);
      check("rst_err", {31'd0, a_err}, 32'd0);
      #2 rst_n = 1'b1;

      // "123456789" contiguous
      load_digits();
      @(posedge clk); #1;
      send_frame(9, 0, -1);
      wait_done("digits", 9, 16'h29B1, 1'b0);

      // Single byte 'A'
      tx[0] = 8'h41;
      send_frame(1, 0, -1);
      wait_done("single", 1, 16'hB915, 1'b0);

      // "123456789" with bubbles on in_valid
      load_digits();
      send_frame(9, 5, -1);
      wait_done("gaps", 9, 16'h29B1, 1'b0);

      // wr_start pulsed mid-frame must be ignored
      send_frame(9, 0, 4);
      wait_done("midstart", 9, 16'h29B1, 1'b0);

      // Back-to-back frames: "A" then "123456789"
      tx[0] = 8'h41;
      send_frame(1, 0, -1);
      wait_done("b2b_a", 1, 16'hB915, 1'b0);
      load_digits();
      send_frame(9, 0, -1);
      wait_done("b2b_digits", 9, 16'h29B1, 1'b0);

      // Asynchronous reset mid-frame
      @(posedge clk); #1 wr_start = 1'b1;
      @(posedge clk); #1 wr_start = 1'b0;
      clear_counts();
      in_data = 8'h55; in_valid = 1'b1; in_last = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ready", {31'd0, a_ready}, 32'd0);
      check("arst_we", {31'd0, a_we}, 32'd0);
      check("arst_addr", {22'd0, a_addr}, 32'd0);
      check("arst_wdata", {24'd0, a_wdata}, 32'd0);
      check("arst_crc", {16'd0, a_crc}, 32'd0);
      check("arst_len", {22'd0, a_len}, 32'd0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("arst_nodone", done_cnt, 32'd0);
      load_digits();
      @(posedge clk); #1;
      send_frame(9, 0, -1);
      wait_done("after_rst", 9, 16'h29B1, 1'b0);

      // Overflow on the MAX_LEN=4 instance: six bytes, no in_last
      sel = 1'b1;
      @(posedge clk); #1 wr_start = 1'b1;
      @(posedge clk); #1 wr_start = 1'b0;
      clear_counts();
      acc = 0;
      r = 1'b1;
      for (int t = 0; t < 6; t++) begin
         in_data = 8'(t + 1); in_valid = 1'b1; in_last = 1'b0;
         tx[t] = 8'(t + 1);
         @(negedge clk);
         if (t == 4) r = w_ready;
         if (w_ready) begin
            @(posedge clk); #1;
            acc++;
            acc_cyc = cyc;
         end else begin
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      check("ovf_accepts", acc, 32'd4);
      check("ovf_ready_low", {31'd0, r}, 32'd0);
      wait_done("ovf", 4, 16'h89C3, 1'b1);
      @(posedge clk); #1 wr_start = 1'b1;
      @(posedge clk); #1 wr_start = 1'b0;
      @(negedge clk);
      check("ovf_err_clr", {31'd0, w_err}, 32'd0);
      // finish the frame B just opened with a single 'A'
      tx[0] = 8'h41;
      @(posedge clk); #1;
      send_frame(1, 0, -1);
      wait_done("ovf_next", 1, 16'hB915, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/crc_frame_writer.md
# crc_frame_writer

Producer-side counterpart of the CRC checker. Accepts a byte stream over a valid/ready handshake, writes each byte into the shared frame memory starting at address 0, and computes CRC-16 on the fly. After the last byte it appends the CRC high byte, then the CRC low byte, to the memory. It then reports completion so the checker can be started on the same memory image.

## Interface

Parameters:
- ADDR_W, 10, memory address width.
- MAX_LEN, 1022, maximum payload bytes. Must satisfy MAX_LEN + 2 <= 2**ADDR_W.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (clk50m, rst_n).
- clk50m  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- wr_start  in  1  single-cycle pulse that starts a frame; ignored unless in IDLE.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  the current byte is the final payload byte.
- in_ready  out  1  block accepts a byte this cycle.
- mem_addr  out  ADDR_W  memory write address.
- mem_wdata  out  8  memory write data.
- mem_we  out  1  memory write enable, one byte per cycle.
- crc_out  out  16  final CRC of the last completed frame.
- frame_len  out  ADDR_W  payload byte count of the last completed frame.
- wr_done  out  1  one-cycle pulse when the frame is fully written.
- wr_err  out  1  overflow flag; sticky until the next accepted wr_start.

## Operation

- CRC algorithm: CRC-16/CCITT-FALSE.
  - Polynomial 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Processes one full byte per clock; the 8 bit steps are unrolled combinationally.
- State machine: IDLE -> DATA -> CRC_HI -> CRC_LO -> DONE -> IDLE.
- IDLE:
  - in_ready=0.
  - wr_start=1: clear ptr to 0, load crc to 0xFFFF, clear wr_err, go to DATA.
- DATA:
  - in_ready=1.
  - On accept (in_valid & in_ready):
    - register mem_we=1, mem_addr=ptr, mem_wdata=in_data;
    - update crc with in_data;
    - increment ptr.
  - If in_last=1 on accept: go to CRC_HI.
  - Overflow: if the accepted byte has ptr==MAX_LEN-1 and in_last=0, treat it as last, set wr_err=1 and go to CRC_HI.
  - Accepts nothing beyond MAX_LEN bytes.
- CRC_HI: mem_we=1, mem_addr=ptr, mem_wdata=crc[15:8]; increment ptr.
- CRC_LO: mem_we=1, mem_addr=ptr, mem_wdata=crc[7:0].
- DONE:
  - mem_we=0, wr_done=1;
  - crc_out<=crc;
  - frame_len<=payload count;
  - return to IDLE.
- crc_out and frame_len hold their values until the next DONE.
- wr_start outside IDLE is ignored, including during DONE.
- in_valid outside DATA is ignored.
- A frame always has at least 1 payload byte. There is no abort input; only rst_n abandons a frame.

## Timing

- Reset values:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - crc_out=0, frame_len=0, wr_done=0, wr_err=0;
  - state=IDLE, internal crc=0xFFFF.
- All outputs are registered except in_ready, which is decoded from the state.
- wr_start sampled high at edge T: in_ready=1 from T+1.
- A byte accepted at edge A appears on mem_we/mem_addr/mem_wdata during cycle A..A+1. Bubbles in in_valid give mem_we=0 cycles.
- Last byte accepted at edge E:
  - E: last payload write;
  - E+1: crc[15:8] write to addr N;
  - E+2: crc[7:0] write to addr N+1;
  - E+3: mem_we=0, wr_done=1, crc_out and frame_len valid;
  - E+4: wr_done=0 and IDLE.
- Earliest next wr_start is sampled at edge E+4.
- rst_n asserted mid-frame: all outputs return to reset values immediately, no wr_done, and the memory contents are undefined.
- ptr never wraps, because the overflow rule stops it at MAX_LEN+1.

## Test plan

- ASCII "123456789", contiguous, in_last on '9':
  - memory addresses 0..8 hold the bytes; addr 9 = 0x29; addr 10 = 0xB1;
  - crc_out=0x29B1, frame_len=9, wr_err=0;
  - wr_done is a single pulse exactly 3 cycles after the last accept edge.
- Single byte 0x41 with in_last: addr 0=0x41, addr 1=0xB9, addr 2=0x15, crc_out=0xB915, frame_len=1.
- "123456789" with in_valid randomly deasserted for 1-5 cycles between bytes:
  - identical memory image and crc_out=0x29B1;
  - mem_we high only in cycles following accepts.
- MAX_LEN overridden to 4; send 6 bytes 0x01..0x06 without in_last:
  - addresses 0..3 hold 0x01..0x04; CRC written at addresses 4 and 5;
  - in_ready=0 after the 4th accept; wr_err=1, frame_len=4;
  - the next wr_start clears wr_err.
- wr_start pulsed during DATA: no effect on ptr or crc.
  - rst_n pulsed mid-frame: outputs go to reset values and no wr_done.
  - A following "123456789" frame gives crc_out=0x29B1.
- Two back-to-back frames ("A", then "123456789"):
  - crc is re-initialised to 0xFFFF for each frame, giving 0xB915 then 0x29B1;
  - the second frame overwrites memory from address 0.
